// File: rtl/mvm_stream.sv
// rtl/mvm_stream.sv - streaming matrix-vector multiply with NUM_MAC MAC lanes
//
// Computes result[i] = sum_k x[k] * W[i][k] over DEPTH column beats.
// Each accepted beat carries one vector element and one matrix column.
// The datapath has two stages:
//   - the product register stage;
//   - the accumulate stage, with optional clamping.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clr             synchronous abort/clear, highest priority
//   start           begin an operation (honoured only in IDLE)
//   mode_signed     operand signedness, latched at start
//   vec_valid/ready vector beat handshake, vec_data = x[k]
//   mat_valid/ready matrix beat handshake, mat_data lane i = W[i][k]
//   busy            operation in progress (RUN, DRAIN, DONE)
//   done            one-cycle completion pulse (DONE state)
//   result_valid    result is final; held until next start, clr or reset
//   result          packed lane sums, lane i at [i*ACC_WIDTH +: ACC_WIDTH]
module mvm_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_MAC    = 8,
  parameter int DEPTH      = 8,
  parameter int ACC_WIDTH  = 3*DATA_WIDTH,
  parameter bit SATURATE   = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clr,
  input  logic                            start,
  input  logic                            mode_signed,
  input  logic                            vec_valid,
  output logic                            vec_ready,
  input  logic [DATA_WIDTH-1:0]           vec_data,
  input  logic                            mat_valid,
  output logic                            mat_ready,
  input  logic [NUM_MAC*DATA_WIDTH-1:0]   mat_data,
  output logic                            busy,
  output logic                            done,
  output logic                            result_valid,
  output logic [NUM_MAC*ACC_WIDTH-1:0]    result
);

  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int PROD_W = 2*DATA_WIDTH;
  localparam logic [CNT_W-1:0]     LAST_BEAT = CNT_W'(DEPTH-1);
  localparam logic [ACC_WIDTH-1:0] U_MAX     = '1;
  localparam logic [ACC_WIDTH-1:0] S_MAX     = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] S_MIN     = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state;
  logic [CNT_W-1:0]     beat_cnt;
  logic                 mode_q;
  logic                 prod_vld;
  logic                 result_valid_q;
  logic [PROD_W-1:0]    prod_q [NUM_MAC];
  logic [ACC_WIDTH-1:0] acc_q  [NUM_MAC];
  logic [NUM_MAC-1:0]   sat_q;

  logic [PROD_W-1:0]    x_ext;
  logic [PROD_W-1:0]    w_ext  [NUM_MAC];
  logic [PROD_W-1:0]    prod_d [NUM_MAC];
  logic [ACC_WIDTH-1:0] p_ext  [NUM_MAC];
  logic [ACC_WIDTH:0]   sum    [NUM_MAC];
  logic [ACC_WIDTH-1:0] acc_d  [NUM_MAC];
  logic [NUM_MAC-1:0]   sat_d;
  logic                 accept;

  // clr blocks acceptance so an aborted beat never reaches the product stage
  assign accept = (state == RUN) && vec_valid && mat_valid && !clr;

  // Stage 1: operands are extended to the product width before multiplying.
  // The low PROD_W bits of that product equal the true signed (or unsigned)
  // product, so one multiplier serves both modes.
  always_comb begin
    x_ext = {{DATA_WIDTH{mode_q & vec_data[DATA_WIDTH-1]}}, vec_data};
    for (int i = 0; i < NUM_MAC; i++) begin
      w_ext[i]  = {{DATA_WIDTH{mode_q & mat_data[i*DATA_WIDTH+DATA_WIDTH-1]}},
                   mat_data[i*DATA_WIDTH +: DATA_WIDTH]};
      prod_d[i] = x_ext * w_ext[i];
    end
  end

  // Stage 2: accumulate with optional clamping. sat_q makes a clamp sticky
  // so a later product of opposite sign cannot pull the lane back.
  always_comb begin
    for (int i = 0; i < NUM_MAC; i++) begin
      if (mode_q) p_ext[i] = ACC_WIDTH'($signed(prod_q[i]));
      else        p_ext[i] = ACC_WIDTH'(prod_q[i]);
      sum[i]   = {1'b0, acc_q[i]} + {1'b0, p_ext[i]};
      acc_d[i] = acc_q[i];
      sat_d[i] = sat_q[i];
      if (prod_vld && !sat_q[i]) begin
        acc_d[i] = sum[i][ACC_WIDTH-1:0];
        if (SATURATE) begin
          if (!mode_q && sum[i][ACC_WIDTH]) begin
            acc_d[i] = U_MAX;
            sat_d[i] = 1'b1;
          end else if (mode_q && !acc_q[i][ACC_WIDTH-1] && !p_ext[i][ACC_WIDTH-1]
                       && sum[i][ACC_WIDTH-1]) begin
            acc_d[i] = S_MAX;
            sat_d[i] = 1'b1;
          end else if (mode_q && acc_q[i][ACC_WIDTH-1] && p_ext[i][ACC_WIDTH-1]
                       && !sum[i][ACC_WIDTH-1]) begin
            acc_d[i] = S_MIN;
            sat_d[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      beat_cnt       <= '0;
      mode_q         <= 1'b0;
      prod_vld       <= 1'b0;
      result_valid_q <= 1'b0;
      sat_q          <= '0;
      for (int i = 0; i < NUM_MAC; i++) begin
        prod_q[i] <= '0;
        acc_q[i]  <= '0;
      end
    end else if (clr) begin
      state          <= IDLE;
      beat_cnt       <= '0;
      prod_vld       <= 1'b0;
      result_valid_q <= 1'b0;
      sat_q          <= '0;
      for (int i = 0; i < NUM_MAC; i++) begin
        prod_q[i] <= '0;
        acc_q[i]  <= '0;
      end
    end else begin
      prod_vld <= accept;
      if (accept) prod_q <= prod_d;

      // prod_vld is only ever set from RUN, so outside a start the
      // accumulators can take acc_d unconditionally
      if (state == IDLE && start) begin
        sat_q <= '0;
        for (int i = 0; i < NUM_MAC; i++) acc_q[i] <= '0;
      end else begin
        sat_q <= sat_d;
        acc_q <= acc_d;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state          <= RUN;
            beat_cnt       <= '0;
            mode_q         <= mode_signed;
            result_valid_q <= 1'b0;
          end
        end
        RUN: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == LAST_BEAT) state <= DRAIN;
          end
        end
        DRAIN: begin
          // last product lands in the accumulators on this edge
          state          <= DONE;
          result_valid_q <= 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign vec_ready    = (state == RUN);
  assign mat_ready    = (state == RUN);
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign result_valid = result_valid_q;

  for (genvar g = 0; g < NUM_MAC; g++) begin : g_pack
    assign result[g*ACC_WIDTH +: ACC_WIDTH] = acc_q[g];
  end

endmodule

// File: tb/tb_mvm_stream.sv
// tb/tb_mvm_stream.sv - directed self-checking bench for mvm_stream
module tb_mvm_stream;
  localparam int NM = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         clr = 1'b0;
  logic         start = 1'b0;
  logic         mode_signed = 1'b0;
  logic         vec_valid = 1'b0;
  logic         mat_valid = 1'b0;
  logic [7:0]   vec_data = '0;
  logic [63:0]  mat_data = '0;

  logic         a_vr, a_mr, a_busy, a_done, a_rv;
  logic [191:0] a_res;
  logic         b_vr, b_mr, b_busy, b_done, b_rv;
  logic [127:0] b_res;
  logic         c_vr, c_mr, c_busy, c_done, c_rv;
  logic [127:0] c_res;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mvm_stream u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .mode_signed(mode_signed),
    .vec_valid(vec_valid), .vec_ready(a_vr), .vec_data(vec_data),
    .mat_valid(mat_valid), .mat_ready(a_mr), .mat_data(mat_data),
    .busy(a_busy), .done(a_done), .result_valid(a_rv), .result(a_res)
  );

  mvm_stream #(.ACC_WIDTH(16), .SATURATE(1'b0)) u_wrap16 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .mode_signed(mode_signed),
    .vec_valid(vec_valid), .vec_ready(b_vr), .vec_data(vec_data),
    .mat_valid(mat_valid), .mat_ready(b_mr), .mat_data(mat_data),
    .busy(b_busy), .done(b_done), .result_valid(b_rv), .result(b_res)
  );

  mvm_stream #(.ACC_WIDTH(16), .SATURATE(1'b1)) u_sat16 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .mode_signed(mode_signed),
    .vec_valid(vec_valid), .vec_ready(c_vr), .vec_data(vec_data),
    .mat_valid(mat_valid), .mat_ready(c_mr), .mat_data(mat_data),
    .busy(c_busy), .done(c_done), .result_valid(c_rv), .result(c_res)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // lane i expected = lane_w ? k*(i+1) : k
  task automatic chk_a(input string tag, input bit lane_w, input logic [23:0] k);
    logic [23:0] e;
    for (int i = 0; i < NM; i++) begin
      e = lane_w ? 24'(int'(k) * (i + 1)) : k;
      chk($sformatf("%s[%0d]", tag, i), 64'(a_res[i*24 +: 24]), 64'(e));
    end
  endtask

  task automatic set_mat(input bit lane_w, input logic [7:0] wc);
    for (int i = 0; i < NM; i++) mat_data[i*8 +: 8] = lane_w ? 8'(i + 1) : wc;
  endtask

  // Runs one full operation on the default instance and leaves it in DONE.
  task automatic run_op(input string tag, input logic [7:0] xv, input bit lane_w,
                        input logic [7:0] wc, input bit sgn, input bit bp);
    int nb;
    int c;
    bit early;
    start = 1'b1;
    mode_signed = sgn;
    step();
    start = 1'b0;
    mode_signed = ~sgn;
    chk({tag, "_ready"}, 64'({a_vr, a_mr}), 64'(2'b11));
    vec_data = xv;
    set_mat(lane_w, wc);
    nb = 0;
    c = 0;
    early = 1'b0;
    while (nb < 8 && c < 200) begin
      vec_valid = bp ? (c % 2 == 0) : 1'b1;
      mat_valid = bp ? (c % 3 != 2) : 1'b1;
      step();
      if (vec_valid && mat_valid) nb++;
      c++;
      early |= a_done;
    end
    vec_valid = 1'b0;
    mat_valid = 1'b0;
    chk({tag, "_beats"}, 64'(nb), 64'(8));
    chk({tag, "_early_done"}, 64'(early), 64'(0));
    chk({tag, "_drain"}, 64'({a_busy, a_done, a_vr}), 64'(3'b100));
    step();
    chk({tag, "_done"}, 64'({a_done, a_rv, a_busy}), 64'(3'b111));
  endtask

  task automatic finish_op(input string tag);
    step();
    chk({tag, "_idle"}, 64'({a_done, a_busy, a_rv}), 64'(3'b001));
  endtask

  initial begin
    bit seen_done;

    // reset state
    #1 rst_n = 1'b0;
    step();
    step();
    chk("rst_ctrl", 64'({a_busy, a_done, a_rv, a_vr, a_mr}), 64'(0));
    chk("rst_res", 64'(|a_res), 64'(0));
    rst_n = 1'b1;
    step();
    chk("idle_ready", 64'({a_vr, a_mr}), 64'(0));

    // unsigned, x=1, W[i]=i+1 -> 8*(i+1)
    run_op("u029", 8'h01, 1'b1, 8'h00, 1'b0, 1'b0);
    chk_a("u029", 1'b1, 24'd8);
    finish_op("u029");
    chk("u029_hold", 64'(a_res[23:0]), 64'(8));

    // signed, x=-1, W=2 -> -16
    run_op("s030", 8'hFF, 1'b0, 8'h02, 1'b1, 1'b0);
    chk_a("s030", 1'b0, 24'hFFFFF0);
    finish_op("s030");

    // backpressure
    run_op("bp031", 8'h01, 1'b1, 8'h00, 1'b0, 1'b1);
    chk_a("bp031", 1'b1, 24'd8);
    finish_op("bp031");

    // all 0xFF: 8*0xFE01 = 0x7F008
    run_op("ff032", 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0);
    chk_a("ff032", 1'b0, 24'h07F008);
    for (int i = 0; i < NM; i++) begin
      chk($sformatf("wrap16[%0d]", i), 64'(b_res[i*16 +: 16]), 64'h0000_F008);
      chk($sformatf("sat16[%0d]", i), 64'(c_res[i*16 +: 16]), 64'h0000_FFFF);
    end
    chk("sat16_rv", 64'({b_rv, c_rv}), 64'(2'b11));
    finish_op("ff032");

    // clr after 3 beats
    start = 1'b1;
    mode_signed = 1'b0;
    step();
    start = 1'b0;
    vec_data = 8'h01;
    set_mat(1'b1, 8'h00);
    vec_valid = 1'b1;
    mat_valid = 1'b1;
    step();
    step();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    vec_valid = 1'b0;
    mat_valid = 1'b0;
    chk("clr_ctrl", 64'({a_busy, a_done, a_rv, a_vr}), 64'(0));
    chk("clr_res", 64'(|a_res), 64'(0));
    run_op("clr_rerun", 8'h01, 1'b1, 8'h00, 1'b0, 1'b0);
    chk_a("clr_rerun", 1'b1, 24'd8);
    finish_op("clr_rerun");

    // start and clr together: stay idle
    start = 1'b1;
    clr = 1'b1;
    step();
    start = 1'b0;
    clr = 1'b0;
    chk("start_clr_idle", 64'({a_busy, a_vr, a_rv}), 64'(0));

    // async reset mid-RUN
    start = 1'b1;
    step();
    start = 1'b0;
    vec_data = 8'h01;
    set_mat(1'b1, 8'h00);
    vec_valid = 1'b1;
    mat_valid = 1'b1;
    step();
    step();
    vec_valid = 1'b0;
    mat_valid = 1'b0;
    chk("pre_rst_lane0", 64'(a_res[23:0]), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", 64'({a_busy, a_done, a_rv, a_vr, a_mr}), 64'(0));
    chk("async_rst_res", 64'(|a_res), 64'(0));
    step();
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      seen_done |= a_done;
    end
    chk("no_done_after_rst", 64'({seen_done, a_busy}), 64'(0));

    // start honoured on the first edge after reset release
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_first_edge", 64'({a_busy, a_vr}), 64'(2'b11));
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("final_clr", 64'(a_busy), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
